srpt_grant_pacer: RTL and testbench

//  Sits between the srpt_grant_queue output FIFO and the grant packet egress FIFO.

---
 rtl/srpt_grant_pacer.sv | 147 ++++++++++++++
 tb/tb_srpt_grant_pacer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/srpt_grant_pacer.sv
// srpt_grant_pacer
// Pacing scheduler on the grant path. It pops one grant entry at a time from
// the upstream FWFT FIFO and holds it. The entry is released downstream only
// when three things are true:
//   - the outstanding byte budget has room for it,
//   - the minimum inter-grant gap has elapsed,
//   - the egress FIFO has space.
// Received DATA bytes return credit to the budget.

module srpt_grant_pacer #(
    parameter logic [31:0] MAX_OUTSTANDING = 32'd65536,
    parameter logic [7:0]  GAP_CYCLES      = 8'd4
) (
    input  logic         ap_clk,
    input  logic         ap_rst,
    input  logic         ap_ce,
    input  logic         grant_in_empty_i,
    input  logic [124:0] grant_in_data_i,
    output logic         grant_in_read_en_o,
    input  logic         grant_out_full_i,
    output logic         grant_out_write_en_o,
    output logic [124:0] grant_out_data_o,
    input  logic         data_rx_valid_i,
    input  logic [15:0]  data_rx_bytes_i,
    output logic [31:0]  outstanding_o,
    output logic         stall_o,
    output logic         underflow_o
);

    // IDLE waits for an entry to pop; EVAL holds exactly one popped entry.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EVAL = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [124:0]   data_q, data_d;
    logic [31:0]    outstanding_q, outstanding_d;
    logic [7:0]     gap_q, gap_d;
    logic           underflow_q, underflow_d;

    // Internal decision signals.
    logic [31:0]    grant_bytes;
    logic [32:0]    budget_sum;
    logic           fits;
    logic           issue_ok;
    logic           pop;
    logic           issue;
    logic [32:0]    credit_sum;
    logic [32:0]    credit_ret;
    logic [32:0]    credit_net;

    // Credit field of the held entry; the remaining fields pass through unmodified.
    assign grant_bytes = data_q[31:0];

    // The budget check is done in 33 bits so a large grant cannot wrap past the limit.
    // It uses the registered outstanding count, so same-cycle credit does not count yet.
    // An empty budget always admits the held grant, so an oversize grant cannot deadlock.
    assign budget_sum = {1'b0, outstanding_q} + {1'b0, grant_bytes};
    assign fits       = (budget_sum <= {1'b0, MAX_OUTSTANDING}) || (outstanding_q == 32'd0);
    assign issue_ok   = (gap_q == 8'd0) && !grant_out_full_i && fits;

    // Strobes are qualified by the clock enable and suppressed during reset.
    // A held entry is therefore dropped, not written, when reset hits in EVAL.
    assign pop   = ap_ce && !ap_rst && (state_q == ST_IDLE) && !grant_in_empty_i;
    assign issue = ap_ce && !ap_rst && (state_q == ST_EVAL) && issue_ok;

    // Net outstanding after this cycle's issue and credit return.
    // Underflow is judged on the net result, not on the credit alone.
    assign credit_sum = {1'b0, outstanding_q} + (issue ? {1'b0, grant_bytes} : 33'd0);
    assign credit_ret = data_rx_valid_i ? {17'd0, data_rx_bytes_i} : 33'd0;
    assign credit_net = credit_sum - credit_ret;

    // Next-state logic: the FSM, the gap counter and the outstanding/underflow update.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave
        // one unassigned and infer a latch.
        state_d       = state_q;
        data_d        = data_q;
        gap_d         = gap_q;
        outstanding_d = outstanding_q;
        underflow_d   = underflow_q;

        if (ap_ce) begin
            // The gap counts down in any state. An issue reloads it; issue is only
            // possible at zero, so reload and decrement never collide.
            if (gap_q != 8'd0) begin
                gap_d = gap_q - 8'd1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        data_d  = grant_in_data_i;
                        state_d = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (issue) begin
                        gap_d   = GAP_CYCLES;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Clamp at zero on underflow. Otherwise saturate at the 32-bit ceiling.
            if (credit_ret > credit_sum) begin
                outstanding_d = 32'd0;
                underflow_d   = 1'b1;
            end else if (credit_net[32]) begin
                outstanding_d = 32'hFFFF_FFFF;
            end else begin
                outstanding_d = credit_net[31:0];
            end
        end
    end

    // State registers. Synchronous reset wins over the clock enable.
    always_ff @(posedge ap_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples the values from before the edge. Blocking assignments here would
        // make the result depend on statement order.
        if (ap_rst) begin
            state_q       <= ST_IDLE;
            data_q        <= '0;
            outstanding_q <= 32'd0;
            gap_q         <= 8'd0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            outstanding_q <= outstanding_d;
            gap_q         <= gap_d;
            underflow_q   <= underflow_d;
        end
    end

    // Output drive. Stall flags a held entry that is blocked by budget, gap or full.
    assign grant_in_read_en_o   = pop;
    assign grant_out_write_en_o = issue;
    assign grant_out_data_o     = data_q;
    assign outstanding_o        = outstanding_q;
    assign stall_o              = !ap_rst && (state_q == ST_EVAL) && !issue_ok;
    assign underflow_o          = underflow_q;

endmodule

// File: tb/tb_srpt_grant_pacer.sv
// Directed testbench for srpt_grant_pacer with MAX_OUTSTANDING=65536 and GAP_CYCLES=4.
// Inputs change 1 time unit after the rising edge. Outputs are sampled after they settle.

module tb_srpt_grant_pacer;

    logic         ap_clk = 1'b0;
    logic         ap_rst;
    logic         ap_ce;
    logic         grant_in_empty_i;
    logic [124:0] grant_in_data_i;
    logic         grant_in_read_en_o;
    logic         grant_out_full_i;
    logic         grant_out_write_en_o;
    logic [124:0] grant_out_data_o;
    logic         data_rx_valid_i;
    logic [15:0]  data_rx_bytes_i;
    logic [31:0]  outstanding_o;
    logic         stall_o;
    logic         underflow_o;

    int n_cmp = 0;
    int n_err = 0;

    srpt_grant_pacer #(
        .MAX_OUTSTANDING (32'd65536),
        .GAP_CYCLES      (8'd4)
    ) dut (
        .ap_clk               (ap_clk),
        .ap_rst               (ap_rst),
        .ap_ce                (ap_ce),
        .grant_in_empty_i     (grant_in_empty_i),
        .grant_in_data_i      (grant_in_data_i),
        .grant_in_read_en_o   (grant_in_read_en_o),
        .grant_out_full_i     (grant_out_full_i),
        .grant_out_write_en_o (grant_out_write_en_o),
        .grant_out_data_o     (grant_out_data_o),
        .data_rx_valid_i      (data_rx_valid_i),
        .data_rx_bytes_i      (data_rx_bytes_i),
        .outstanding_o        (outstanding_o),
        .stall_o              (stall_o),
        .underflow_o          (underflow_o)
    );

    always #5 ap_clk = ~ap_clk;

    // Assemble an entry: peer_id, local_id, message_length, grant_offset, grant_bytes.
    function automatic logic [124:0] mk(input logic [14:0] peer, input logic [13:0] loc,
                                        input logic [31:0] len, input logic [31:0] off,
                                        input logic [31:0] bytes);
        return {peer, loc, len, off, bytes};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle. Leave 1 time unit past the edge for the registers to settle.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [124:0] e1, e2, e3, e4, e5, e6, e7, e8, e9;
    int           wr_cyc [0:3];
    logic [124:0] wr_dat [0:3];
    int           nwr;
    int           pops;
    logic         rd;

    initial begin
        e1 = mk(15'd1, 14'd10, 32'd5000,   32'd0,    32'd1000);
        e2 = mk(15'd2, 14'd20, 32'd90000,  32'd1000, 32'd64000);
        e3 = mk(15'd3, 14'd30, 32'd2000,   32'd0,    32'd1000);
        e4 = mk(15'd4, 14'd40, 32'd300,    32'd0,    32'd100);
        e5 = mk(15'd5, 14'd50, 32'd300,    32'd100,  32'd100);
        e6 = mk(15'd6, 14'd60, 32'd200000, 32'd0,    32'd100000);
        e7 = mk(15'd7, 14'd70, 32'd10,     32'd0,    32'd10);
        e8 = mk(15'd8, 14'd80, 32'd50,     32'd0,    32'd50);
        e9 = mk(15'h7FFF, 14'h3FFF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'd10);

        ap_rst           = 1'b1;
        ap_ce            = 1'b1;
        grant_in_empty_i = 1'b1;
        grant_in_data_i  = '0;
        grant_out_full_i = 1'b0;
        data_rx_valid_i  = 1'b0;
        data_rx_bytes_i  = '0;

        // Reset state.
        idle(2);
        check("rst_outstanding", 128'(outstanding_o), 128'd0);
        check("rst_write_en",    128'(grant_out_write_en_o), 128'd0);
        check("rst_data",        128'(grant_out_data_o), 128'd0);
        check("rst_stall",       128'(stall_o), 128'd0);
        check("rst_underflow",   128'(underflow_o), 128'd0);
        ap_rst = 1'b0;

        // 1. Idle with an empty upstream FIFO.
        idle(3);
        check("idle_read_en",     128'(grant_in_read_en_o), 128'd0);
        check("idle_write_en",    128'(grant_out_write_en_o), 128'd0);
        check("idle_outstanding", 128'(outstanding_o), 128'd0);

        // 2. Single 1000-byte grant: pop at N, write at N+1, count visible at N+2.
        grant_in_empty_i = 1'b0; grant_in_data_i = e1; #1;
        check("t2_pop",      128'(grant_in_read_en_o), 128'd1);
        check("t2_no_write", 128'(grant_out_write_en_o), 128'd0);
        tick();
        grant_in_empty_i = 1'b1; #1;
        check("t2_write",    128'(grant_out_write_en_o), 128'd1);
        check("t2_data",     128'(grant_out_data_o), 128'(e1));
        check("t2_no_pop",   128'(grant_in_read_en_o), 128'd0);
        tick();
        check("t2_outstanding", 128'(outstanding_o), 128'd1000);
        check("t2_write_done",  128'(grant_out_write_en_o), 128'd0);

        // 3. Budget stall. Bring outstanding to 65000, then offer 1000 more bytes.
        idle(6);
        grant_in_empty_i = 1'b0; grant_in_data_i = e2; #1;
        check("t3_pop_fill", 128'(grant_in_read_en_o), 128'd1);
        tick();
        grant_in_empty_i = 1'b1; #1;
        check("t3_write_fill", 128'(grant_out_write_en_o), 128'd1);
        tick();
        check("t3_out_65000", 128'(outstanding_o), 128'd65000);
        idle(6);
        grant_in_empty_i = 1'b0; grant_in_data_i = e3; #1;
        tick();
        grant_in_empty_i = 1'b1; #1;
        check("t3_stall",    128'(stall_o), 128'd1);
        check("t3_no_write", 128'(grant_out_write_en_o), 128'd0);
        tick();
        data_rx_valid_i = 1'b1; data_rx_bytes_i = 16'd500; #1;
        check("t3_stall_rx_cycle", 128'(stall_o), 128'd1);
        check("t3_no_write_rx",    128'(grant_out_write_en_o), 128'd0);
        tick();
        data_rx_valid_i = 1'b0; #1;
        check("t3_out_64500",  128'(outstanding_o), 128'd64500);
        check("t3_write",      128'(grant_out_write_en_o), 128'd1);
        check("t3_data",       128'(grant_out_data_o), 128'(e3));
        check("t3_stall_gone", 128'(stall_o), 128'd0);
        tick();
        check("t3_out_65500", 128'(outstanding_o), 128'd65500);

        // 4. Gap spacing. Return all credit, then offer two back-to-back entries.
        data_rx_valid_i = 1'b1; data_rx_bytes_i = 16'd65500;
        tick();
        data_rx_valid_i = 1'b0;
        check("t4_out_zero", 128'(outstanding_o), 128'd0);
        idle(6);
        grant_in_empty_i = 1'b0; grant_in_data_i = e4; #1;
        pops = 0; nwr = 0;
        for (int i = 0; i < 24; i++) begin
            rd = grant_in_read_en_o;
            if (grant_out_write_en_o && nwr < 4) begin
                wr_cyc[nwr] = i;
                wr_dat[nwr] = grant_out_data_o;
                nwr++;
            end
            tick();
            if (rd) begin
                pops++;
                if (pops == 1) grant_in_data_i = e5;
                else           grant_in_empty_i = 1'b1;
            end
            #1;
        end
        check("t4_write_count", 128'(nwr), 128'd2);
        check("t4_spacing",     128'(wr_cyc[1] - wr_cyc[0]), 128'd5);
        check("t4_data0",       128'(wr_dat[0]), 128'(e4));
        check("t4_data1",       128'(wr_dat[1]), 128'(e5));
        check("t4_outstanding", 128'(outstanding_o), 128'd200);

        // 5. An oversize grant passes alone. The next 10-byte grant waits for credit.
        data_rx_valid_i = 1'b1; data_rx_bytes_i = 16'd200;
        tick();
        data_rx_valid_i = 1'b0;
        idle(6);
        grant_in_empty_i = 1'b0; grant_in_data_i = e6; #1;
        tick();
        grant_in_empty_i = 1'b1; #1;
        check("t5_oversize_write", 128'(grant_out_write_en_o), 128'd1);
        tick();
        check("t5_out_100000", 128'(outstanding_o), 128'd100000);
        idle(5);
        grant_in_empty_i = 1'b0; grant_in_data_i = e7; #1;
        tick();
        grant_in_empty_i = 1'b1;
        data_rx_valid_i = 1'b1; data_rx_bytes_i = 16'd34473; #1;
        check("t5_stall_a", 128'(stall_o), 128'd1);
        tick();
        data_rx_bytes_i = 16'd1; #1;
        check("t5_out_65527", 128'(outstanding_o), 128'd65527);
        check("t5_stall_b",   128'(stall_o), 128'd1);
        check("t5_no_write",  128'(grant_out_write_en_o), 128'd0);
        tick();
        data_rx_valid_i = 1'b0; #1;
        check("t5_out_65526", 128'(outstanding_o), 128'd65526);
        check("t5_write",     128'(grant_out_write_en_o), 128'd1);
        tick();
        check("t5_out_65536", 128'(outstanding_o), 128'd65536);

        // 6. Full holds the write. Then credit exceeds the issue in the same cycle.
        data_rx_valid_i = 1'b1; data_rx_bytes_i = 16'd65436;
        tick();
        data_rx_valid_i = 1'b0;
        check("t6_out_100", 128'(outstanding_o), 128'd100);
        idle(6);
        grant_out_full_i = 1'b1;
        grant_in_empty_i = 1'b0; grant_in_data_i = e8; #1;
        tick();
        grant_in_empty_i = 1'b1; #1;
        check("t6_full_stall",    128'(stall_o), 128'd1);
        check("t6_full_no_write", 128'(grant_out_write_en_o), 128'd0);
        tick();
        check("t6_full_hold", 128'(grant_out_write_en_o), 128'd0);
        grant_out_full_i = 1'b0;
        data_rx_valid_i  = 1'b1; data_rx_bytes_i = 16'd300; #1;
        check("t6_write",          128'(grant_out_write_en_o), 128'd1);
        check("t6_data",           128'(grant_out_data_o), 128'(e8));
        check("t6_underflow_pre",  128'(underflow_o), 128'd0);
        tick();
        data_rx_valid_i = 1'b0; #1;
        check("t6_out_clamped", 128'(outstanding_o), 128'd0);
        check("t6_underflow",   128'(underflow_o), 128'd1);
        idle(6);
        check("t6_underflow_sticky", 128'(underflow_o), 128'd1);

        // Clock enable freezes the pop. Reset in EVAL drops the held entry.
        ap_ce = 1'b0;
        grant_in_empty_i = 1'b0; grant_in_data_i = e9; #1;
        check("ce_no_pop", 128'(grant_in_read_en_o), 128'd0);
        tick();
        ap_ce = 1'b1; #1;
        check("ce_pop", 128'(grant_in_read_en_o), 128'd1);
        tick();
        grant_in_empty_i = 1'b1; ap_ce = 1'b0; #1;
        check("ce_no_write", 128'(grant_out_write_en_o), 128'd0);
        ap_ce = 1'b1; ap_rst = 1'b1; #1;
        check("rst_eval_no_write", 128'(grant_out_write_en_o), 128'd0);
        tick();
        check("rst_eval_data",      128'(grant_out_data_o), 128'd0);
        check("rst_eval_underflow", 128'(underflow_o), 128'd0);
        check("rst_eval_stall",     128'(stall_o), 128'd0);
        ap_rst = 1'b0;
        tick();
        check("rst_eval_idle_write", 128'(grant_out_write_en_o), 128'd0);
        check("rst_eval_idle_out",   128'(outstanding_o), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
